counter_sweep_ctrl: RTL and testbench
=====================================

# counter_sweep_ctrl

Sequencer for the 6-bit up/down counter datapath used by the counter scope. It owns the count register and steps it between programmable bounds at a programmable rate, in one of four sweep modes, under start/stop/hold control. It sits between the front-panel/host control logic and the display or scope capture that consumes `count`.

## Interface
- `WIDTH`, 6: count width.
- `DIV_W`, 24: prescaler divisor width.

- `clock` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_lo` in WIDTH: lower sweep bound.
- `cfg_hi` in WIDTH: upper sweep bound.
- `cfg_mode` in 2: 0 single-up, 1 single-down, 2 repeat-up, 3 bounce.
- `cfg_div` in DIV_W: step period minus one, in clock cycles.
- `start` in 1: one-cycle pulse, begin sweep.
- `stop` in 1: one-cycle pulse, abort sweep.
- `hold` in 1: level, freeze sweep while high.
- `count` out WIDTH: current count.
- `dir_out` out 1: 0 counting up, 1 counting down.
- `busy` out 1: high in RUN or PAUSE.
- `done` out 1: one-cycle pulse, single sweep finished.
- `wrap` out 1: one-cycle pulse on bound reversal or wrap.
- `err` out 1: one-cycle pulse, start rejected.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset: IDLE, count=0, dir_out=0, busy=0, done=0, wrap=0, err=0, prescaler=0.
- IDLE/DONE + start: latch cfg_*.
  - If cfg_lo > cfg_hi: pulse err, stay IDLE.
  - Otherwise enter RUN with prescaler=0 and count/dir set by mode: mode 1 loads cfg_hi with dir=1; all other modes load cfg_lo with dir=0.
- Start while RUN/PAUSE is ignored, with no err.
- Config inputs are sampled only on an accepted start.
- RUN: prescaler counts 0..div. When prescaler==div, the step fires and the prescaler returns to 0.
  - Mode 0: +1. At count==hi, the step enters DONE with count held at hi.
  - Mode 1: −1. At count==lo, the step enters DONE with count held at lo.
  - Mode 2: +1. At count==hi, the step loads lo and pulses wrap.
  - Mode 3: step in the direction of dir. At a bound, the step toggles dir, pulses wrap and leaves count unchanged for that step; count then moves away from the bound on the next step.
- lo==hi: mode 0/1 enter DONE on the first step. Mode 2/3 pulse wrap on every step, and mode 3 also toggles dir.
- RUN + hold: enter PAUSE. Prescaler and count are frozen. Hold low returns to RUN, and the prescaler resumes from its frozen value.
- stop in any state: next state IDLE. count and dir_out hold their last values. No done pulse.
- stop and start in the same cycle: stop wins.
- stop and step in the same cycle: stop wins, so no step, wrap or done occurs.
- hold and step in the same cycle: hold wins, so no step occurs.
- DONE lasts exactly one cycle, then IDLE. `done` is high in DONE.
- Arithmetic is modulo 2^WIDTH; it cannot overflow within legal bounds.

## Timing
- All outputs are registered.
- Accepted start at edge N: busy=1 and count=start value from N+1.
- First count change: div+1 cycles after entering RUN. Thereafter one step every div+1 cycles, so div=0 steps every cycle.
- wrap, done and err are each high for exactly one cycle, coincident with the count/state update they report.
- Asserting rst at any point forces the reset values immediately, regardless of clock.

## Structure
- Shared package `counter_pkg`: state encoding (IDLE/RUN/PAUSE/DONE) and mode constants (MODE_SINGLE_UP=0, MODE_SINGLE_DN=1, MODE_REPEAT_UP=2, MODE_BOUNCE=3).
- Sub-module `tick_gen`: DIV_W prescaler with inputs clear, enable and div, and a registered step output. The FSM and count register remain in `counter_sweep_ctrl`.

## Test plan
- Mode 0, lo=3, hi=6, div=0, start → count goes 3,4,5,6 on consecutive cycles; done one cycle later; busy 0 afterwards; count holds 6.
- Mode 3, lo=0, hi=2, div=1 → count 0,1,2,2,1,0,0,1… changing every 2 cycles; wrap at each repeated bound value; dir_out toggles at each bound.
- Mode 2, lo=62, hi=63, div=0 → 62,63,62,63…; wrap pulses on each 63→62.
- Hold for 5 cycles mid-step, div=3 → no count change during hold; the next step lands exactly div+1 total enabled cycles after the previous step.
- start with lo=10, hi=5 → err pulse, state stays IDLE. Then start and stop in the same cycle → stays IDLE, busy 0.
- Assert rst mid-RUN between clock edges → count=0 and busy=0 immediately. A stop during RUN → IDLE next cycle with count frozen.

Source files
------------

// File: rtl/counter_sweep_ctrl_pkg.sv
// Shared types for the counter sweep sequencer.
// Holds the FSM state encoding and sweep mode codes.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_SINGLE_UP = 2'd0;
  localparam logic [1:0] MODE_SINGLE_DN = 2'd1;
  localparam logic [1:0] MODE_REPEAT_UP = 2'd2;
  localparam logic [1:0] MODE_BOUNCE    = 2'd3;

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// Control/status bundle between the host and the sweep sequencer.
// The host drives config and strobes; the sequencer drives status.
interface counter_sweep_ctrl_if #(
  parameter int WIDTH = 6,
  parameter int DIV_W = 24
);

  logic [WIDTH-1:0] cfg_lo;
  logic [WIDTH-1:0] cfg_hi;
  logic [1:0]       cfg_mode;
  logic [DIV_W-1:0] cfg_div;
  logic             start;
  logic             stop;
  logic             hold;
  logic [WIDTH-1:0] count;
  logic             dir_out;
  logic             busy;
  logic             done;
  logic             wrap;
  logic             err;

  modport master (
    output cfg_lo, cfg_hi, cfg_mode, cfg_div,
    output start, stop, hold,
    input  count, dir_out, busy,
    input  done, wrap, err
  );

  modport slave (
    input  cfg_lo, cfg_hi, cfg_mode, cfg_div,
    input  start, stop, hold,
    output count, dir_out, busy,
    output done, wrap, err
  );

endinterface

// File: rtl/counter_sweep_ctrl_tick_gen.sv
// Step-rate prescaler: counts 0..div while enabled.
// o_step is a flop that is high while the count sits at div.
module tick_gen #(
  parameter int DIV_W = 24
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_step
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_step;
  logic [DIV_W-1:0] w_nxt;

  assign w_nxt  = r_cnt + 1'b1;
  assign o_step = r_step;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_step <= 1'b0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_step <= (i_div == '0);
    end else if (i_en) begin
      if (r_step) begin
        r_cnt  <= '0;
        r_step <= (i_div == '0);
      end else begin
        r_cnt  <= w_nxt;
        r_step <= (w_nxt == i_div);
      end
    end
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer: owns the count register and steps it
// between latched bounds in one of four modes.
module counter_sweep_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DIV_W = 24
) (
  input logic clock,
  input logic rst,
  counter_sweep_ctrl_if.slave bus
);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [1:0]       r_mode;
  logic [DIV_W-1:0] r_div;
  logic             r_dir;
  logic             r_busy;
  logic             r_done;
  logic             r_wrap;
  logic             r_err;

  logic             w_idle;
  logic             w_bad;
  logic             w_accept;
  logic             w_en;
  logic             w_tick;
  logic [DIV_W-1:0] w_div;

  assign w_idle   = (r_state == ST_IDLE)
                 || (r_state == ST_DONE);
  assign w_bad    = bus.cfg_lo > bus.cfg_hi;
  assign w_accept = w_idle && bus.start
                 && !bus.stop && !w_bad;
  assign w_en     = !w_idle && !bus.hold
                 && !bus.stop;
  // prescaler preloads its step flag from the div being latched
  assign w_div    = w_accept ? bus.cfg_div : r_div;

  tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clock   (clock),
    .rst     (rst),
    .i_clear (w_accept),
    .i_en    (w_en),
    .i_div   (w_div),
    .o_step  (w_tick)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_mode  <= MODE_SINGLE_UP;
      r_div   <= '0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
      if (bus.stop) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE, ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            if (bus.start && w_bad) begin
              r_err <= 1'b1;
            end else if (w_accept) begin
              r_lo    <= bus.cfg_lo;
              r_hi    <= bus.cfg_hi;
              r_mode  <= bus.cfg_mode;
              r_div   <= bus.cfg_div;
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
              if (bus.cfg_mode == MODE_SINGLE_DN) begin
                r_count <= bus.cfg_hi;
                r_dir   <= 1'b1;
              end else begin
                r_count <= bus.cfg_lo;
                r_dir   <= 1'b0;
              end
            end
          end
          ST_RUN, ST_PAUSE: begin
            if (bus.hold) begin
              r_state <= ST_PAUSE;
            end else begin
              r_state <= ST_RUN;
              if (w_tick) begin
                unique case (r_mode)
                  MODE_SINGLE_UP: begin
                    if (r_count == r_hi) begin
                      r_state <= ST_DONE;
                      r_busy  <= 1'b0;
                      r_done  <= 1'b1;
                    end else begin
                      r_count <= r_count + 1'b1;
                    end
                  end
                  MODE_SINGLE_DN: begin
                    if (r_count == r_lo) begin
                      r_state <= ST_DONE;
                      r_busy  <= 1'b0;
                      r_done  <= 1'b1;
                    end else begin
                      r_count <= r_count - 1'b1;
                    end
                  end
                  MODE_REPEAT_UP: begin
                    if (r_count == r_hi) begin
                      r_count <= r_lo;
                      r_wrap  <= 1'b1;
                    end else begin
                      r_count <= r_count + 1'b1;
                    end
                  end
                  MODE_BOUNCE: begin
                    // a bound costs one step: turn around in place
                    if (!r_dir) begin
                      if (r_count == r_hi) begin
                        r_dir  <= 1'b1;
                        r_wrap <= 1'b1;
                      end else begin
                        r_count <= r_count + 1'b1;
                      end
                    end else if (r_count == r_lo) begin
                      r_dir  <= 1'b0;
                      r_wrap <= 1'b1;
                    end else begin
                      r_count <= r_count - 1'b1;
                    end
                  end
                endcase
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.count   = r_count;
  assign bus.dir_out = r_dir;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.wrap    = r_wrap;
  assign bus.err     = r_err;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: directed sweeps then random
// strobes, each cycle compared against a behavioural model.
module tb_counter_sweep_ctrl;
  import counter_pkg::*;

  logic clock = 1'b0;
  logic rst;

  always #5 clock = ~clock;

  counter_sweep_ctrl_if #(
    .WIDTH (6),
    .DIV_W (24)
  ) bus ();

  counter_sweep_ctrl #(
    .WIDTH (6),
    .DIV_W (24)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  // model: 0 idle, 1 running, 2 paused, 3 finished
  int m_st, m_cnt, m_dir, m_ph;
  int m_lo, m_hi, m_mode, m_div;
  bit e_wrap, e_err;

  function automatic void model_reset();
    m_st = 0; m_cnt = 0; m_dir = 0; m_ph = 0;
    m_lo = 0; m_hi = 0; m_mode = 0; m_div = 0;
    e_wrap = 0; e_err = 0;
  endfunction

  function automatic void model_update();
    bit at;
    e_wrap = 0;
    e_err  = 0;
    if (bus.stop) begin
      m_st = 0;
      return;
    end
    if (m_st == 0 || m_st == 3) begin
      m_st = 0;
      if (bus.start) begin
        if (bus.cfg_lo > bus.cfg_hi) begin
          e_err = 1;
        end else begin
          m_lo   = int'(bus.cfg_lo);
          m_hi   = int'(bus.cfg_hi);
          m_mode = int'(bus.cfg_mode);
          m_div  = int'(bus.cfg_div);
          m_ph   = 0;
          m_dir  = (m_mode == 1) ? 1 : 0;
          m_cnt  = m_dir ? m_hi : m_lo;
          m_st   = 1;
        end
      end
      return;
    end
    if (bus.hold) begin
      m_st = 2;
      return;
    end
    m_st = 1;
    if (m_ph < m_div) begin
      m_ph++;
      return;
    end
    m_ph = 0;
    case (m_mode)
      0: if (m_cnt == m_hi) m_st = 3;
         else m_cnt = m_cnt + 1;
      1: if (m_cnt == m_lo) m_st = 3;
         else m_cnt = m_cnt - 1;
      2: if (m_cnt == m_hi) begin
           m_cnt  = m_lo;
           e_wrap = 1;
         end else m_cnt = m_cnt + 1;
      default: begin
        at = m_dir ? (m_cnt == m_lo)
                   : (m_cnt == m_hi);
        if (at) begin
          m_dir  = 1 - m_dir;
          e_wrap = 1;
        end else begin
          m_cnt = m_cnt + (m_dir ? -1 : 1);
        end
      end
    endcase
    m_cnt = m_cnt % 64;
  endfunction

  task automatic compare_all(input string pfx);
    chk({pfx, "count"}, 32'(bus.count), m_cnt);
    chk({pfx, "dir"}, 32'(bus.dir_out), m_dir);
    chk({pfx, "busy"}, 32'(bus.busy),
        (m_st == 1 || m_st == 2) ? 1 : 0);
    chk({pfx, "done"}, 32'(bus.done),
        (m_st == 3) ? 1 : 0);
    chk({pfx, "wrap"}, 32'(bus.wrap), e_wrap);
    chk({pfx, "err"}, 32'(bus.err), e_err);
  endtask

  task automatic set_cfg(input int lo, input int hi,
                         input int mode, input int div);
    bus.cfg_lo   = 6'(lo);
    bus.cfg_hi   = 6'(hi);
    bus.cfg_mode = 2'(mode);
    bus.cfg_div  = 24'(div);
  endtask

  task automatic cyc(input bit s, input bit p,
                     input bit h);
    bus.start = s;
    bus.stop  = p;
    bus.hold  = h;
    @(posedge clock);
    model_update();
    @(negedge clock);
    compare_all("");
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  task automatic do_reset();
    bus.start = 0;
    bus.stop  = 0;
    bus.hold  = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all("rst_");
    @(negedge clock);
    rst = 1'b0;
    compare_all("rst_rel_");
  endtask

  int lo, hi, tmp, hold_left;

  initial begin
    rst = 1'b1;
    set_cfg(0, 0, 0, 0);
    bus.start = 0;
    bus.stop  = 0;
    bus.hold  = 0;
    model_reset();
    #1 compare_all("init_");
    @(negedge clock);
    rst = 1'b0;

    set_cfg(3, 6, 0, 0);
    cyc(1, 0, 0);
    idle_n(8);

    set_cfg(0, 2, 3, 1);
    cyc(1, 0, 0);
    idle_n(20);
    cyc(0, 1, 0);
    idle_n(2);

    set_cfg(62, 63, 2, 0);
    cyc(1, 0, 0);
    idle_n(8);
    cyc(0, 1, 0);
    idle_n(3);

    set_cfg(0, 40, 0, 3);
    cyc(1, 0, 0);
    idle_n(6);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1);
    idle_n(10);
    set_cfg(9, 9, 1, 0);
    cyc(1, 0, 0);
    idle_n(3);
    cyc(0, 1, 0);
    idle_n(2);

    set_cfg(10, 5, 0, 0);
    cyc(1, 0, 0);
    idle_n(1);
    set_cfg(1, 4, 0, 0);
    cyc(1, 1, 0);
    idle_n(2);

    set_cfg(7, 7, 3, 0);
    cyc(1, 0, 0);
    idle_n(6);
    cyc(0, 1, 0);
    set_cfg(7, 7, 1, 1);
    cyc(1, 0, 0);
    idle_n(5);

    set_cfg(5, 30, 2, 2);
    cyc(1, 0, 0);
    idle_n(7);
    do_reset();
    idle_n(2);

    hold_left = 0;
    for (int n = 0; n < 6000; n++) begin
      bit s, p, h;
      if ($urandom % 5 == 0) begin
        lo = $urandom_range(0, 63);
        hi = lo + $urandom_range(0, 8);
        if (hi > 63) hi = 63;
        if ($urandom % 8 == 0) begin
          tmp = lo; lo = hi; hi = tmp;
        end
        set_cfg(lo, hi, $urandom % 4,
                ($urandom % 4 == 0)
                  ? $urandom_range(0, 6)
                  : $urandom_range(0, 1));
      end
      s = ($urandom % 6 == 0);
      p = ($urandom % 50 == 0);
      if (hold_left > 0) begin
        h = 1;
        hold_left--;
      end else begin
        h = 0;
        if ($urandom % 25 == 0)
          hold_left = $urandom_range(1, 6);
      end
      if ($urandom % 800 == 0) do_reset();
      else cyc(s, p, h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
